// File: rtl/uart_rx_bit_sampler.sv
// UART RX oversampling front end: line synchronizer, edge/bit counters,
// mid-bit single or three-sample majority sampling and frame-end pulse.
module uart_rx_bit_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  SAMPLE_MODE,
    input  logic                  PAR_EN,
    input  logic                  enable,
    output logic [3:0]            BIT_COUNT,
    output logic [PRESCALE_W-1:0] EDGE_COUNT,
    output logic                  sampled_bit,
    output logic                  sample_one_bit,
    output logic                  sample_three_bit,
    output logic                  frame_done
);

    logic [1:0]            r_sync;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_mode;
    logic                  r_par;
    logic [PRESCALE_W-1:0] r_edge;
    logic [3:0]            r_bit;
    logic                  r_sbit;
    logic                  r_one;
    logic                  r_three;
    logic                  r_done;
    logic                  r_v0;
    logic                  r_v1;

    logic                  w_rx_s;
    logic [PRESCALE_W-1:0] w_p_even;
    logic [PRESCALE_W-1:0] w_p;
    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic [3:0]            w_last_bit;
    logic                  w_maj;

    assign w_rx_s      = r_sync[1];
    // Odd ratios round down to even; anything under 8 runs as 8.
    assign w_p_even    = {r_prescale[PRESCALE_W-1:1], 1'b0};
    assign w_p         = (w_p_even < PRESCALE_W'(8)) ? PRESCALE_W'(8) : w_p_even;
    assign w_mid       = w_p >> 1;
    assign w_last_edge = w_p - PRESCALE_W'(1);
    assign w_last_bit  = r_par ? 4'd10 : 4'd9;
    assign w_maj       = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_prescale <= PRESCALE_W'(8);
            r_mode     <= 1'b0;
            r_par      <= 1'b0;
            r_edge     <= '0;
            r_bit      <= '0;
            r_sbit     <= 1'b0;
            r_one      <= 1'b0;
            r_three    <= 1'b0;
            r_done     <= 1'b0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], RX_IN};
            r_one   <= 1'b0;
            r_three <= 1'b0;
            r_done  <= 1'b0;
            if (!enable) begin
                // Config only tracks the inputs between frames.
                r_prescale <= Prescale;
                r_mode     <= SAMPLE_MODE;
                r_par      <= PAR_EN;
                r_edge     <= '0;
                r_bit      <= '0;
            end else begin
                if (r_edge == w_last_edge) begin
                    r_edge <= '0;
                    if (r_bit == w_last_bit) begin
                        r_bit  <= '0;
                        r_done <= 1'b1;
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end else begin
                    r_edge <= r_edge + PRESCALE_W'(1);
                end

                if (!r_mode) begin
                    if (r_edge == w_mid) begin
                        r_sbit <= w_rx_s;
                        r_one  <= 1'b1;
                    end
                end else begin
                    if (r_edge == w_mid - PRESCALE_W'(1)) r_v0 <= w_rx_s;
                    if (r_edge == w_mid) r_v1 <= w_rx_s;
                    if (r_edge == w_mid + PRESCALE_W'(1)) begin
                        r_sbit  <= w_maj;
                        r_three <= 1'b1;
                    end
                end
            end
        end
    end

    assign BIT_COUNT        = r_bit;
    assign EDGE_COUNT       = r_edge;
    assign sampled_bit      = r_sbit;
    assign sample_one_bit   = r_one;
    assign sample_three_bit = r_three;
    assign frame_done       = r_done;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler; expected strobes are queued at
// frame start and matched by a negedge monitor.
module tb_uart_rx_bit_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       SAMPLE_MODE;
    logic       PAR_EN;
    logic       enable;
    logic [3:0] BIT_COUNT;
    logic [5:0] EDGE_COUNT;
    logic       sampled_bit;
    logic       sample_one_bit;
    logic       sample_three_bit;
    logic       frame_done;

    uart_rx_bit_sampler #(.PRESCALE_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .Prescale(Prescale),
        .SAMPLE_MODE(SAMPLE_MODE), .PAR_EN(PAR_EN), .enable(enable),
        .BIT_COUNT(BIT_COUNT), .EDGE_COUNT(EDGE_COUNT), .sampled_bit(sampled_bit),
        .sample_one_bit(sample_one_bit), .sample_three_bit(sample_three_bit),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bidx;
        logic       val;
        logic [5:0] edge_c;
        logic       mode;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_err = 0;
    int   n_checks = 0;
    int   n_strobe = 0;
    int   n_fd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (sample_one_bit || sample_three_bit)) begin
            n_strobe++;
            chk("strobe_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                m_e = q.pop_front();
                chk("strobe_type", {sample_three_bit, sample_one_bit}, m_e.mode ? 2'b10 : 2'b01);
                chk("strobe_bitcount", BIT_COUNT, m_e.bidx);
                chk("strobe_edgecount", EDGE_COUNT, m_e.edge_c);
                chk("sampled_bit", sampled_bit, m_e.val);
            end
        end
        if (frame_done) n_fd++;
    end

    // Line value the synchronized sampler should see at frame tick g.
    function automatic logic desired(input int g, input int p, input int l,
                                     input logic [15:0] pat, input int gb,
                                     input int gs, input int gl);
        int   b = g / p;
        int   t = g % p;
        logic v = (b <= l) ? pat[b] : 1'b1;
        if (gl > 0 && b == gb && t >= gs && t < gs + gl) v = 1'b0;
        return v;
    endfunction

    task automatic run_frame(input int pin, input bit mode, input bit par, input int p,
                             input int l, input logic [15:0] pat, input int gb,
                             input int gs, input int gl, input int abort_at,
                             input int chg_at);
        int   n_total = p * (l + 1);
        int   mid = p / 2;
        int   s0, f0, fd_at, n_exp, g;
        logic a, b, c;
        exp_t e;
        Prescale = 6'(pin); SAMPLE_MODE = mode; PAR_EN = par; enable = 1'b0;
        RX_IN = desired(0, p, l, pat, gb, gs, gl);
        repeat (3) @(negedge clk);
        n_exp = 0;
        for (int bi = 0; bi <= l; bi++) begin
            g = bi * p + mid;
            if (abort_at >= 0 && g + (mode ? 1 : 0) >= abort_at) continue;
            if (!mode) begin
                e.val = desired(g, p, l, pat, gb, gs, gl);
            end else begin
                a = desired(g - 1, p, l, pat, gb, gs, gl);
                b = desired(g, p, l, pat, gb, gs, gl);
                c = desired(g + 1, p, l, pat, gb, gs, gl);
                e.val = (a & b) | (a & c) | (b & c);
            end
            e.bidx = 4'(bi); e.edge_c = 6'(mid + 1 + (mode ? 1 : 0)); e.mode = mode;
            q.push_back(e);
            n_exp++;
        end
        s0 = n_strobe; f0 = n_fd; fd_at = -1;
        enable = 1'b1;
        RX_IN = desired(2, p, l, pat, gb, gs, gl);
        for (int n = 1; n <= n_total; n++) begin
            @(negedge clk);
            if (frame_done && fd_at < 0) fd_at = n;
            RX_IN = desired(n + 2, p, l, pat, gb, gs, gl);
            if (n == chg_at) begin Prescale = 6'd32; PAR_EN = 1'b0; end
            if (n == abort_at) begin
                chk("abort_edge_pos", EDGE_COUNT, 6'(mid));
                chk("abort_bit_pos", BIT_COUNT, 4'd4);
                enable = 1'b0;
            end
            if (abort_at >= 0 && n == abort_at + 1) begin
                chk("abort_edge_clr", EDGE_COUNT, 6'd0);
                chk("abort_bit_clr", BIT_COUNT, 4'd0);
                chk("abort_no_strobe", {sample_three_bit, sample_one_bit}, 2'b00);
            end
        end
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("frame_done_cycle", fd_at, (abort_at >= 0) ? -1 : n_total);
        chk("frame_done_count", n_fd - f0, (abort_at >= 0) ? 0 : 1);
        chk("strobe_count", n_strobe - s0, n_exp);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; SAMPLE_MODE = 1'b0;
        PAR_EN = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {BIT_COUNT, EDGE_COUNT, sampled_bit, sample_one_bit,
                              sample_three_bit, frame_done}, 14'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame(8, 0, 0, 8, 9, 16'b10_1001_1010, 0, 0, 0, -1, -1);
        run_frame(16, 1, 0, 16, 9, 16'h03AA, 3, 7, 1, -1, -1);
        run_frame(16, 1, 0, 16, 9, 16'h03AA, 3, 7, 2, -1, -1);
        run_frame(16, 0, 1, 16, 10, 16'h0555, 0, 0, 0, -1, -1);
        run_frame(8, 0, 1, 8, 10, 16'h02D6, 0, 0, 0, -1, 20);
        run_frame(32, 0, 0, 32, 9, 16'h02D6, 0, 0, 0, -1, -1);
        run_frame(8, 0, 0, 8, 9, 16'b10_1001_1010, 0, 0, 0, 36, -1);
        run_frame(5, 1, 0, 8, 9, 16'h0336, 5, 3, 1, -1, -1);

        // Reset asserted while a strobe is high.
        Prescale = 6'd8; SAMPLE_MODE = 1'b0; PAR_EN = 1'b0; RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        m_e.bidx = 4'd0; m_e.val = 1'b1; m_e.edge_c = 6'd5; m_e.mode = 1'b0;
        q.push_back(m_e);
        enable = 1'b1;
        k = 0;
        while (!sample_one_bit && k < 100) begin @(negedge clk); k++; end
        chk("rst_strobe_seen", sample_one_bit, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {BIT_COUNT, EDGE_COUNT, sampled_bit, sample_one_bit,
                                      sample_three_bit, frame_done}, 14'd0);
        q.delete();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k = n_strobe;
        repeat (50) @(negedge clk);
        chk("idle_no_strobes", n_strobe - k, 0);
        chk("idle_counters", {BIT_COUNT, EDGE_COUNT}, 10'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_bit_sampler.md
Name: uart_rx_bit_sampler

Overview:
Oversampling front end of the UART receiver. It synchronizes RX_IN and runs the edge and bit counters. It samples each bit at mid-bit, either as a single sample or as a three-sample majority vote. It feeds the RX deserializer through sampled_bit, the sample_one_bit/sample_three_bit strobes and BIT_COUNT, and tells the RX FSM when a frame's last bit period ends.

Parameters:
PRESCALE_W, 6, width of Prescale input and EDGE_COUNT output

Ports:
clk  input  1  system clock (oversampling clock)
rst_n  input  1  reset, asynchronous, active-low
RX_IN  input  1  asynchronous serial line, idle high
Prescale  input  PRESCALE_W  oversampling ratio, legal values 8, 16, 32
SAMPLE_MODE  input  1  0 = single mid-bit sample, 1 = three-sample majority
PAR_EN  input  1  parity bit present in frame
enable  input  1  from RX FSM, high while a frame is being received
BIT_COUNT  output  4  index of current bit, 0 = start bit
EDGE_COUNT  output  PRESCALE_W  oversample tick within current bit
sampled_bit  output  1  sampled value, valid while a strobe is high
sample_one_bit  output  1  one-cycle strobe, mode 0 sample ready
sample_three_bit  output  1  one-cycle strobe, mode 1 majority ready
frame_done  output  1  one-cycle pulse, last bit period completed

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Synchronizer flops reset to 1. BIT_COUNT, EDGE_COUNT, sampled_bit, both strobes, frame_done and vote registers reset to 0. Config registers reset to P=8, mode 0, PAR_EN 0.
- Synchronizer: RX_IN passes through 2 flops to give rx_s. All sampling uses rx_s, which lags RX_IN by 2 clk.
- Config latch: Prescale, SAMPLE_MODE and PAR_EN load into config registers on every clk edge with enable=0. They are frozen while enable=1, so input changes mid-frame are ignored.
- Effective P: latched Prescale with LSB forced to 0. Any value below 8 is treated as 8. mid = P/2.
- Last bit index L = 10 if PAR_EN is latched high, else 9.
- Counters, enable=0: EDGE_COUNT and BIT_COUNT load 0. No strobes, no frame_done. sampled_bit holds its value.
- Counters, enable=1: EDGE_COUNT increments each clk.
- Bit wrap: at EDGE_COUNT=P-1, EDGE_COUNT goes to 0 and BIT_COUNT increments.
- Frame end: at EDGE_COUNT=P-1 with BIT_COUNT=L, both counters go to 0 and frame_done pulses high for 1 cycle. The pulse is registered and visible in the cycle after that edge.
- First enabled cycle always has EDGE_COUNT=0 and BIT_COUNT=0.
- Mode 0:
  - At the clk edge where enable=1 and EDGE_COUNT=mid: sampled_bit <= rx_s and sample_one_bit <= 1 for exactly 1 cycle.
  - sample_three_bit stays 0.
- Mode 1:
  - Capture rx_s into v0 at EDGE_COUNT=mid-1 and into v1 at mid.
  - At EDGE_COUNT=mid+1: sampled_bit <= majority(v0, v1, rx_s) and sample_three_bit <= 1 for 1 cycle.
  - sample_one_bit stays 0.
- Strobe/BIT_COUNT alignment: every strobe cycle falls before the bit wrap (mid+2 <= P-1 for P>=8). BIT_COUNT in the strobe cycle therefore equals the index of the bit just sampled, and the deserializer writes at that index.
- Strobe count: exactly one strobe per bit period, so L+1 strobes per complete frame.
- Enable drop mid-frame: counters clear at the next edge and no further strobe or frame_done is produced. Any strobe registered on that same edge is suppressed (strobes require enable=1). Vote registers are not cleared; they are always overwritten before use.
- Simultaneous enable low and frame end on the same edge: enable wins, so no frame_done.
- Async reset mid-frame: all state returns to reset values immediately. Strobes drop in the same cycle.
- Back-to-back frames: if enable stays high after frame_done, counting restarts from bit 0 with no gap.

Test Plan:
- P=8, mode 0, PAR_EN=0, enable high, line driven 0,1,0,1,1,0,0,1,0,1 per 8 clk -> 10 sample_one_bit pulses at EDGE_COUNT=4 with BIT_COUNT 0..9, sampled_bit matching the pattern; frame_done after clk 80.
- P=16, mode 1, 1-clk low glitch on a high bit at tick 7 -> majority gives sampled_bit=1; a 2-clk low covering ticks 7-8 gives 0; sample_three_bit at EDGE_COUNT=9.
- P=16, PAR_EN=1 -> 11 strobes with BIT_COUNT 0..10; frame_done 176 clk after enable rises.
- Change Prescale 8->32 and PAR_EN 1->0 during an enabled frame -> timing stays P=8, L=10; next frame after enable low uses P=32, L=9.
- Drop enable at BIT_COUNT=4, EDGE_COUNT=mid -> no strobe that edge, counters 0 next cycle, no frame_done.
- Prescale=5 -> behaves as P=8. rst_n low mid-frame -> all outputs 0 immediately; after release, idle line produces no strobes while enable=0.
